tempn_pack_loader: RTL and testbench

//  Upstream feeder for the TempN 26-bit x 2048 distributed RAM. Accepts one centred Rq coefficient per handshake.

---
 rtl/tempn_pack_loader.sv | 188 ++++++++++++++++++
 tb/tb_tempn_pack_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tempn_pack_loader.sv
// tempn_pack_loader
//   Feeds one P-coefficient Rq polynomial into the TempN 26-bit distributed RAM.
//   Each accepted centred coefficient c is mapped to [0,Q-1] (c<0 -> c+Q).
//   Coefficients are packed in pairs: even index in the low half, odd index in the high half.
//   The last (even) coefficient is written alone with a zero high half.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active high
//   start          load one polynomial; sampled only while idle
//   in_valid       in_coef valid
//   in_ready       loader accepts in_coef this cycle (registered)
//   in_coef        signed centred coefficient, legal range -(Q-1)/2..(Q-1)/2
//   write_enable   TempN write strobe
//   write_address  TempN write address
//   input_data     TempN write data {hi_coef, lo_coef}
//   busy           high from the cycle after start through the done cycle
//   done           one-cycle pulse after the final word is written
//   err            sticky out-of-range flag; cleared by the next accepted start
//
// State   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start, in_valid ignored
// S_LOAD  | accepting coefficients, writing a word after each odd index
// S_FLUSH | writing the final unpaired (even-index) coefficient
// S_DONE  | done pulse, then back to idle
//
// P is assumed odd so the final coefficient always lands in the low half.

module tempn_pack_loader #(
  parameter int Q             = 4591,
  parameter int P             = 757,
  parameter int COEF_W        = 13,
  parameter int RAM_WIDTH     = 26,
  parameter int RAM_ADDR_BITS = 11,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W:0]   in_coef,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] write_address,
  output logic [RAM_WIDTH-1:0]     input_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IDX_W = $clog2(P);
  localparam int CW1   = COEF_W + 1;
  localparam int HALF  = (Q - 1) / 2;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(P - 1);
  localparam logic [COEF_W-1:0]        Q_M      = COEF_W'(Q);
  localparam logic signed [COEF_W:0]   C_MAX    = CW1'(HALF);
  localparam logic signed [COEF_W:0]   C_MIN    = -C_MAX;
  localparam logic [RAM_ADDR_BITS-1:0] BASE     = RAM_ADDR_BITS'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [COEF_W-1:0]        lo_q, lo_d;
  logic                     err_q, err_d;

  logic                     in_ready_q, in_ready_d;
  logic                     we_q, we_d;
  logic [RAM_ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [RAM_WIDTH-1:0]     wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     accept;
  logic                     range_bad;
  logic [COEF_W-1:0]        m;

  assign accept    = in_valid & in_ready_q;
  assign range_bad = (in_coef > C_MAX) || (in_coef < C_MIN);

  // c+Q is below 2^COEF_W for every legal negative c, so the low bits are exact.
  assign m = range_bad   ? '0 :
             in_coef[COEF_W] ? (in_coef[COEF_W-1:0] + Q_M) : in_coef[COEF_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (accept && (idx_q == LAST_IDX)) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered below.
  always_comb begin
    idx_d      = idx_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    err_d      = err_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);

    if ((state_q == S_IDLE) && start) begin
      idx_d  = '0;
      addr_d = BASE;
      err_d  = 1'b0;
    end

    if (accept) begin
      idx_d = idx_q + IDX_W'(1);
      if (range_bad) err_d = 1'b1;
      if (idx_q[0]) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = {m, lo_q};
        addr_d  = addr_q + RAM_ADDR_BITS'(1);
      end else begin
        lo_d = m;
        // Final even coefficient: written next cycle (FLUSH) without a partner.
        if (idx_q == LAST_IDX) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {{COEF_W{1'b0}}, m};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      addr_q     <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign input_data    = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_tempn_pack_loader.sv
module tb_tempn_pack_loader;

  localparam int P    = 757;
  localparam int Q    = 4591;
  localparam int BASE = 0;
  localparam int NW   = (P + 1) / 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [13:0] in_coef = '0;
  logic               in_ready;
  logic               write_enable;
  logic [10:0]        write_address;
  logic [25:0]        input_data;
  logic               busy;
  logic               done;
  logic               err;

  tempn_pack_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_coef       (in_coef),
    .write_enable  (write_enable),
    .write_address (write_address),
    .input_data    (input_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit illegal(input int c);
    return (c < -(Q - 1) / 2) || (c > (Q - 1) / 2);
  endfunction

  function automatic int map_coef(input int c);
    if (illegal(c)) return 0;
    return (c < 0) ? c + Q : c;
  endfunction

  // Reference model: tracks what the loader should present in the coming cycle.
  int          mode = 0;  // 0 idle, 1 loading, 2 flushing, 3 done
  int          n = 0;
  int          mapped[P];
  logic        e_we = 0, e_ready = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [10:0] e_addr = '0;
  logic [25:0] e_data = '0;
  bit          chk_en = 0;
  int          negc = 0;
  int          last_acc = 0;
  int          wr_cnt = 0;
  logic [25:0] ram_img[NW];

  always @(negedge clk) begin
    int c, m;
    negc++;
    if (chk_en) begin
      check("write_enable", 32'(write_enable), 32'(e_we));
      check("in_ready", 32'(in_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      if (e_we && write_enable) begin
        check("write_address", 32'(write_address), 32'(e_addr));
        check("input_data", 32'(input_data), 32'(e_data));
      end
      if (write_enable) begin
        wr_cnt++;
        if (int'(write_address) - BASE < NW) ram_img[int'(write_address) - BASE] = input_data;
      end
      if (done && e_done) begin
        check("done_latency", 32'(negc - last_acc), 32'd2);
        check("write_count", 32'(wr_cnt), 32'(NW));
      end
    end

    if (rst) begin
      mode = 0; n = 0; e_err = 0; e_we = 0; wr_cnt = 0;
    end else begin
      e_we = 0;
      case (mode)
        0: if (start) begin mode = 1; n = 0; e_err = 0; wr_cnt = 0; end
        1: if (in_valid) begin
             c = in_coef;
             m = map_coef(c);
             if (illegal(c)) e_err = 1;
             mapped[n] = m;
             if (n % 2 == 1) begin
               e_we = 1; e_addr = 11'(BASE + n / 2); e_data = {13'(m), 13'(mapped[n-1])};
             end
             if (n == P - 1) begin
               mode = 2; e_we = 1; e_addr = 11'(BASE + n / 2); e_data = {13'd0, 13'(m)};
               last_acc = negc;
             end
             n++;
           end
        2: mode = 3;
        default: mode = 0;
      endcase
    end
    e_ready = (mode == 1);
    e_busy  = (mode != 0);
    e_done  = (mode == 3);
    chk_en  = 1;
  end

  int coefs[P];

  task automatic pulse_start;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic feed(input int gap_pct, input bit spam, input int stop_after);
    int i = 0;
    int cyc = 0;
    bit acc;
    while (i < stop_after && cyc < 6000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_coef  = 14'(coefs[i]);
      start    = spam && ($urandom_range(9) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 0;
    start    = 0;
    if (i < stop_after) check("feed_timeout", 32'(i), 32'(stop_after));
  endtask

  task automatic wait_done;
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 10);
    check("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic load(input int gap_pct, input bit spam);
    for (int k = 0; k < NW; k++) ram_img[k] = '1;
    pulse_start();
    feed(gap_pct, spam, P);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_ramp;
    logic [25:0] exp;
    for (int k = 0; k < NW; k++) begin
      exp = (k < NW - 1) ? {13'(2 * k + 1), 13'(2 * k)} : {13'd0, 13'd756};
      check("ramp_word", 32'(ram_img[k]), 32'(exp));
    end
  endtask

  task automatic set_ramp;
    for (int i = 0; i < P; i++) coefs[i] = i;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd0);
    check("reset_we", 32'(write_enable), 32'd0);
    check("reset_data", 32'(input_data), 32'd0);

    // in_valid while idle with no start: nothing happens
    in_valid = 1; in_coef = 14'sd7;
    repeat (8) @(posedge clk);
    #1;
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 0;

    // Ramp, back-to-back
    set_ramp();
    load(0, 0);
    check_ramp();

    // Negative mapping
    for (int i = 0; i < P; i++) coefs[i] = int'($urandom_range(4590)) - 2295;
    coefs[0] = -1;
    coefs[1] = -2295;
    load(0, 0);
    check("neg_word0", 32'(ram_img[0]), 32'({13'd2296, 13'd4590}));
    check("neg_err", 32'(err), 32'd0);

    // Range violation at idx 5
    for (int i = 0; i < P; i++) coefs[i] = 1;
    coefs[5] = 2296;
    load(0, 0);
    check("viol_err", 32'(err), 32'd1);
    check("viol_word2", 32'(ram_img[2]), 32'({13'd0, 13'd1}));
    check("viol_word1", 32'(ram_img[1]), 32'({13'd1, 13'd1}));

    // Ramp with ~50% valid gaps and stray start pulses
    set_ramp();
    load(50, 1);
    check_ramp();
    check("err_cleared", 32'(err), 32'd0);

    // Random coefficients, a few out of range
    for (int i = 0; i < P; i++) begin
      if ($urandom_range(49) == 0) begin
        r = int'($urandom_range(5895)) + 2296;
        if ($urandom_range(1) == 1) r = -r;
      end else begin
        r = int'($urandom_range(4590)) - 2295;
      end
      coefs[i] = r;
    end
    load(30, 0);

    // Reset after 100 accepts, then reload from scratch
    set_ramp();
    pulse_start();
    feed(0, 0, 100);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    check("midrst_we", 32'(write_enable), 32'd0);
    check("midrst_addr", 32'(write_address), 32'd0);
    check("midrst_data", 32'(input_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    load(0, 0);
    check_ramp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
